coin_credit_unit: RTL
=====================

# coin_credit_unit

Upstream credit stage for the vending machine. Accepts coin insertions, accumulates a 4-bit customer credit, and offers it to the customer transaction stage on a valid/ready handshake when the customer presses buy. It then takes the remaining money back and pays it out as change, one coin per cycle. Cancel and an optional inactivity timeout refund the full credit.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT before auto-refund. Must be ≥2. Used only with the timeout feature.
- MAX_CREDIT, 15: credit ceiling. Must be ≤15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin insertion strobe.
- coin_code  in  2  coin denomination: 00=1, 01=2, 10=5, 11=10.
- buy_req  in  1  customer buy strobe.
- cancel_req  in  1  customer cancel strobe.
- credit_out  out  4  current credit; feeds the customer stage's money input.
- credit_valid  out  1  credit offered for a purchase.
- credit_ready  in  1  customer stage accepts the offered credit.
- remaining_valid  in  1  one-cycle strobe carrying change to return.
- remaining_money  in  4  change amount owed.
- change_valid  out  1  one coin dispensed this cycle.
- change_code  out  2  denomination of the dispensed coin, same encoding as coin_code.
- coin_reject  out  1  one-cycle pulse: the inserted coin was returned unaccepted.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, OFFER, SETTLE, PAYOUT.
- IDLE:
  - credit is 0.
  - An accepted coin sets credit to the coin value and moves to COLLECT.
  - buy_req is ignored.
  - cancel_req is ignored.
- COLLECT:
  - An accepted coin adds its value to credit.
  - A coin is rejected (coin_reject pulses, credit unchanged) if credit + value > MAX_CREDIT.
  - cancel_req moves to PAYOUT with payout = credit.
  - buy_req moves to OFFER.
- OFFER:
  - credit_valid=1 and credit_out is held stable.
  - On credit_valid && credit_ready, move to SETTLE.
- SETTLE:
  - Wait for remaining_valid.
  - Latch payout = min(remaining_money, credit), then set credit to 0.
  - Go to PAYOUT, or directly to IDLE if payout is 0.
- PAYOUT:
  - Each cycle, emit one coin by greedy selection: 10 if payout≥10, else 5 if ≥5, else 2 if ≥2, else 1.
  - Subtract the emitted value from payout.
  - Go to IDLE in the cycle after the last coin is emitted.
- Coins arriving in OFFER, SETTLE or PAYOUT are rejected.
- Simultaneous events in COLLECT:
  - cancel_req beats buy_req.
  - cancel_req beats a coin; the coin is rejected.
  - A coin together with buy_req: the coin is added first (if it fits), and OFFER carries the updated credit.
- Arithmetic is 5-bit internally for the overflow check; credit and payout are 4-bit.
- remaining_money > credit is clamped to credit (no over-payout).

## Timing
- Reset: state=IDLE, credit_out=0, credit_valid=0, change_valid=0, change_code=00, coin_reject=0, busy=0, payout=0, timeout counter=0.
- All outputs are registered.
- credit_out reflects an accepted coin one cycle after coin_valid.
- coin_reject pulses one cycle after the offending coin_valid.
- buy_req → credit_valid high on the next cycle.
- credit_valid drops in the cycle after the handshake.
- remaining_valid → first change_valid on the next cycle. Throughput is one coin per cycle.
- Reset mid-operation discards credit and payout immediately; no change is dispensed.

## Configuration
- COIN_TIMEOUT_EN defined:
  - A counter clears on entry to COLLECT and on every accepted coin, and increments on other COLLECT cycles.
  - When it reaches TIMEOUT_CYCLES-1 with no cancel/buy/coin that cycle, go to PAYOUT with payout=credit.
  - An accepted coin in that same cycle resets the counter instead.
- COIN_TIMEOUT_EN undefined: no counter logic; COLLECT is left only by buy_req or cancel_req.

## Structure
- Shared package vm_coin_pkg holds:
  - the state enum;
  - the coin_code encodings;
  - coin-value lookup function (code→4-bit value);
  - MAX_CREDIT default.
- One sub-module, change_dispenser: holds payout, performs greedy denomination selection, and drives change_valid/change_code, with load and done handshakes to the top-level FSM.

## Test plan
- Reset, insert 5 then 2, buy_req, credit_ready one cycle later, remaining_money=3 → credit_valid with credit_out=7, then change coins 2 then 1, IDLE, busy=0.
- Insert 10, 5, then 1 → credit_out=15 and the third coin gets a coin_reject pulse; cancel_req → change 10, 5, then IDLE.
- In COLLECT with credit 2, drive cancel_req and a coin (code 11) in the same cycle → coin rejected; payout 2 emits one coin of code 01.
- Coin 5 together with buy_req in COLLECT from credit 5 → OFFER with credit_out=10; hold credit_ready low for 4 cycles → credit_valid stays high and credit_out stays stable.
- With COIN_TIMEOUT_EN and TIMEOUT_CYCLES=8, insert 1, idle 8 cycles → PAYOUT emits one coin 00 and returns to IDLE; without the macro, the state remains COLLECT.
- Assert rst_n low during PAYOUT with payout 9 → all outputs go to 0 immediately and no further change_valid appears.

Source files
------------

// File: rtl/vm_coin_pkg.sv
// ============================================================================
// Module      : vm_coin_pkg
// Description : Shared states, coin encodings and coin-value lookup for the
//               vending-machine coin path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vm_coin_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_OFFER   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_PAYOUT  = 3'd4
   } state_t;

   localparam logic [1:0] COIN_1  = 2'b00;
   localparam logic [1:0] COIN_2  = 2'b01;
   localparam logic [1:0] COIN_5  = 2'b10;
   localparam logic [1:0] COIN_10 = 2'b11;

   localparam int unsigned MAX_CREDIT_DEFAULT = 15;

   function automatic logic [3:0] coin_value(input logic [1:0] code);
      logic [3:0] v;
      case (code)
         COIN_1:  v = 4'd1;
         COIN_2:  v = 4'd2;
         COIN_5:  v = 4'd5;
         default: v = 4'd10;
      endcase
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Holds the pending payout and emits one greedily chosen coin
//               per cycle; the first coin appears the cycle after load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
   import vm_coin_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic       change_valid,
   output logic [1:0] change_code,
   output logic       done
);

   logic [3:0] r_payout;
   logic       r_valid;
   logic [1:0] r_code;

   logic [3:0] w_src;
   logic [1:0] w_pick;
   logic [3:0] w_pick_val;

   // A load emits its first coin at the same edge it is captured.
   always_comb begin
      w_src = load ? load_value : r_payout;
      if (w_src >= 4'd10)
         w_pick = COIN_10;
      else if (w_src >= 4'd5)
         w_pick = COIN_5;
      else if (w_src >= 4'd2)
         w_pick = COIN_2;
      else
         w_pick = COIN_1;
      w_pick_val = coin_value(w_pick);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_payout <= 4'd0;
         r_valid  <= 1'b0;
         r_code   <= COIN_1;
      end else if (w_src != 4'd0) begin
         r_payout <= w_src - w_pick_val;
         r_valid  <= 1'b1;
         r_code   <= w_pick;
      end else begin
         r_payout <= 4'd0;
         r_valid  <= 1'b0;
         r_code   <= COIN_1;
      end
   end

   assign change_valid = r_valid;
   assign change_code  = r_code;
   assign done         = r_valid && (r_payout == 4'd0);

endmodule

`default_nettype wire

// File: rtl/coin_credit_unit.sv
// ============================================================================
// Module      : coin_credit_unit
// Description : Coin credit accumulation, purchase offer handshake and change
//               payout control. Optional macro COIN_TIMEOUT_EN enables the
//               inactivity auto-refund in COLLECT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_credit_unit
   import vm_coin_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned MAX_CREDIT     = MAX_CREDIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       buy_req,
   input  logic       cancel_req,
   output logic [3:0] credit_out,
   output logic       credit_valid,
   input  logic       credit_ready,
   input  logic       remaining_valid,
   input  logic [3:0] remaining_money,
   output logic       change_valid,
   output logic [1:0] change_code,
   output logic       coin_reject,
   output logic       busy
);

   state_t     r_state;
   logic [3:0] r_credit;
   logic       r_credit_valid;
   logic       r_coin_reject;
   logic       r_busy;

   logic [3:0] w_coin_val;
   logic [4:0] w_sum;
   logic       w_fits;
   logic       w_accept;
   logic [3:0] w_settle_pay;
   logic       w_timeout;
   logic       w_load;
   logic [3:0] w_load_value;
   logic       w_done;

`ifdef COIN_TIMEOUT_EN
   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] r_idle_cnt;
`endif

   always_comb begin
      w_coin_val = coin_value(coin_code);
      w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
      w_fits     = (w_sum <= 5'(MAX_CREDIT));
      w_accept   = 1'b0;
      if (coin_valid && w_fits) begin
         if (r_state == ST_IDLE)
            w_accept = 1'b1;
         else if ((r_state == ST_COLLECT) && !cancel_req)
            w_accept = 1'b1;
      end
      // Change owed never exceeds what the customer put in.
      w_settle_pay = (remaining_money < r_credit) ? remaining_money : r_credit;
      w_timeout    = 1'b0;
`ifdef COIN_TIMEOUT_EN
      w_timeout = (r_state == ST_COLLECT) && (r_idle_cnt == TO_LAST) &&
                  !cancel_req && !buy_req && !coin_valid;
`endif
      w_load       = 1'b0;
      w_load_value = r_credit;
      if ((r_state == ST_COLLECT) && (cancel_req || w_timeout)) begin
         w_load = 1'b1;
      end else if ((r_state == ST_SETTLE) && remaining_valid && (w_settle_pay != 4'd0)) begin
         w_load       = 1'b1;
         w_load_value = w_settle_pay;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_credit       <= 4'd0;
         r_credit_valid <= 1'b0;
         r_coin_reject  <= 1'b0;
         r_busy         <= 1'b0;
`ifdef COIN_TIMEOUT_EN
         r_idle_cnt     <= '0;
`endif
      end else begin
         r_coin_reject <= coin_valid && !w_accept;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_COLLECT;
                  r_credit <= w_sum[3:0];
                  r_busy   <= 1'b1;
`ifdef COIN_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
               end
            end
            ST_COLLECT: begin
               if (cancel_req || w_timeout) begin
                  r_state  <= ST_PAYOUT;
                  r_credit <= 4'd0;
               end else begin
                  if (w_accept)
                     r_credit <= w_sum[3:0];
`ifdef COIN_TIMEOUT_EN
                  if (w_accept)
                     r_idle_cnt <= '0;
                  else if (r_idle_cnt != TO_LAST)
                     r_idle_cnt <= r_idle_cnt + 1'b1;
`endif
                  if (buy_req) begin
                     r_state        <= ST_OFFER;
                     r_credit_valid <= 1'b1;
                  end
               end
            end
            ST_OFFER: begin
               if (credit_ready) begin
                  r_state        <= ST_SETTLE;
                  r_credit_valid <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (remaining_valid) begin
                  r_credit <= 4'd0;
                  if (w_settle_pay != 4'd0) begin
                     r_state <= ST_PAYOUT;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            ST_PAYOUT: begin
               if (w_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_credit       <= 4'd0;
               r_credit_valid <= 1'b0;
               r_busy         <= 1'b0;
            end
         endcase
      end
   end

   change_dispenser u_change_dispenser (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (w_load),
      .load_value   (w_load_value),
      .change_valid (change_valid),
      .change_code  (change_code),
      .done         (w_done)
   );

   assign credit_out   = r_credit;
   assign credit_valid = r_credit_valid;
   assign coin_reject  = r_coin_reject;
   assign busy         = r_busy;

endmodule

`default_nettype wire
